// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mc_ctrl_pkg
//  Brief  : Opcodes, state encodings, ALU/PC select codes and opcode classifier
//           shared by the multi-cycle control unit.
//  Rev    : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    localparam int OP_WIDTH = 6;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLTI  = 6'b011011;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_BLTZ  = 6'b110010;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_LS = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB_LD  = 3'b100,
        ST_EXE_BR = 3'b101,
        ST_EXE_AL = 3'b110,
        ST_WB_AL  = 3'b111
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP  = 3'd0,
        CL_RALU = 3'd1,
        CL_IALU = 3'd2,
        CL_LW   = 3'd3,
        CL_SW   = 3'd4,
        CL_BR   = 3'd5,
        CL_J    = 3'd6,
        CL_HALT = 3'd7
    } op_class_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    function automatic op_class_e op_class(input logic [5:0] op);
        op_class_e cl;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_SLL:     cl = CL_RALU;
            OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: cl = CL_IALU;
            OP_LW:                              cl = CL_LW;
            OP_SW:                              cl = CL_SW;
            OP_BEQ, OP_BNE, OP_BLTZ:            cl = CL_BR;
            OP_J:                               cl = CL_J;
            OP_HALT:                            cl = CL_HALT;
            default:                            cl = CL_NOP;
        endcase
        return cl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module : mc_decode
//  Brief  : Combinational control decode from (state, opcode, ALU flags).
//  Rev    : 1.0  initial release
// ============================================================================
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] state_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       sign_i,
    input  logic       halted_i,
    output logic       irwre_o,
    output logic       pcwre_o,
    output logic [1:0] pcsrc_o,
    output logic       extsel_o,
    output logic       alusrca_o,
    output logic       alusrcb_o,
    output logic [2:0] aluop_o,
    output logic       regdst_o,
    output logic       regwre_o,
    output logic       dbdatasrc_o,
    output logic       nrd_o,
    output logic       nwr_o
);

    state_e    w_state;
    op_class_e w_class;
    logic      w_taken;

    assign w_state = state_e'(state_i);
    assign w_class = op_class(op_i);
    assign w_taken = ((op_i == OP_BEQ)  &&  zero_i) ||
                     ((op_i == OP_BNE)  && !zero_i) ||
                     ((op_i == OP_BLTZ) &&  sign_i);

    always_comb begin
        irwre_o     = 1'b0;
        pcwre_o     = 1'b0;
        pcsrc_o     = PCSRC_SEQ;
        extsel_o    = 1'b0;
        alusrca_o   = 1'b0;
        alusrcb_o   = 1'b0;
        aluop_o     = ALU_ADD;
        regdst_o    = 1'b0;
        regwre_o    = 1'b0;
        dbdatasrc_o = 1'b0;
        nrd_o       = 1'b1;
        nwr_o       = 1'b1;

        if (w_state == ST_IF) begin
            irwre_o = 1'b1;
        end else begin
            // Operand selects stay asserted from ID until the instruction completes.
            case (w_class)
                CL_RALU: begin
                    regdst_o  = 1'b1;
                    alusrca_o = (op_i == OP_SLL);
                    case (op_i)
                        OP_SUB:  aluop_o = ALU_SUB;
                        OP_AND:  aluop_o = ALU_AND;
                        OP_SLL:  aluop_o = ALU_SLL;
                        default: aluop_o = ALU_ADD;
                    endcase
                end
                CL_IALU: begin
                    alusrcb_o = 1'b1;
                    extsel_o  = (op_i == OP_ADDIU) || (op_i == OP_SLTI);
                    case (op_i)
                        OP_ANDI: aluop_o = ALU_AND;
                        OP_ORI:  aluop_o = ALU_OR;
                        OP_SLTI: aluop_o = ALU_SLT;
                        default: aluop_o = ALU_ADD;
                    endcase
                end
                CL_LW: begin
                    alusrcb_o   = 1'b1;
                    extsel_o    = 1'b1;
                    dbdatasrc_o = 1'b1;
                end
                CL_SW: begin
                    alusrcb_o = 1'b1;
                    extsel_o  = 1'b1;
                end
                CL_BR: begin
                    extsel_o = 1'b1;
                    aluop_o  = (op_i == OP_BLTZ) ? ALU_ADD : ALU_SUB;
                end
                default: ;
            endcase

            case (w_state)
                ST_ID: begin
                    if (w_class == CL_J) begin
                        pcwre_o = 1'b1;
                        pcsrc_o = PCSRC_JMP;
                    end else if (w_class == CL_NOP) begin
                        pcwre_o = 1'b1;
                    end
                end
                ST_EXE_BR: begin
                    pcwre_o = 1'b1;
                    if (w_taken) pcsrc_o = PCSRC_BR;
                end
                ST_MEM: begin
                    if (w_class == CL_LW) nrd_o = 1'b0;
                    if (w_class == CL_SW) begin
                        nwr_o   = 1'b0;
                        pcwre_o = 1'b1;
                    end
                end
                ST_WB_LD, ST_WB_AL: begin
                    regwre_o = 1'b1;
                    pcwre_o  = 1'b1;
                end
                default: ;
            endcase

            if (halted_i) begin
                pcwre_o = 1'b0;
                pcsrc_o = PCSRC_SEQ;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module : mc_control_unit
//  Brief  : Multi-cycle CPU sequencer: state register, HALT flag, retire count.
//  Rev    : 1.0  initial release
// ============================================================================
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [OP_W-1:0]  Op,
    input  logic             zero,
    input  logic             sign,
    output logic             IRWre,
    output logic             PCWre,
    output logic [1:0]       PCSrc,
    output logic             ExtSel,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             RegDst,
    output logic             RegWre,
    output logic             DBDataSrc,
    output logic             nRD,
    output logic             nWR,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    op_class_e        w_class;
    logic             w_halt_now;

    assign w_class    = op_class(Op[5:0]);
    // HALT is visible in its first ID cycle, then held by the sticky flag.
    assign w_halt_now = (state_q == ST_ID) && (w_class == CL_HALT);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IF;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = ST_IF;
        halted_d  = halted_q | w_halt_now;
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, PCWre};
        case (state_q)
            ST_IF: state_d = ST_ID;
            ST_ID: begin
                if (halted_q || w_class == CL_HALT) begin
                    state_d = ST_ID;
                end else begin
                    case (w_class)
                        CL_BR:          state_d = ST_EXE_BR;
                        CL_LW, CL_SW:   state_d = ST_EXE_LS;
                        CL_RALU,
                        CL_IALU:        state_d = ST_EXE_AL;
                        default:        state_d = ST_IF;
                    endcase
                end
            end
            ST_EXE_LS: state_d = ST_MEM;
            ST_MEM:    state_d = (w_class == CL_LW) ? ST_WB_LD : ST_IF;
            ST_WB_LD:  state_d = ST_IF;
            ST_EXE_BR: state_d = ST_IF;
            ST_EXE_AL: state_d = ST_WB_AL;
            ST_WB_AL:  state_d = ST_IF;
            default:   state_d = ST_IF;
        endcase
    end

    assign state   = state_q;
    assign halted  = halted_q | w_halt_now;
    assign retired = retired_q;

    mc_decode u_decode (
        .state_i     (state_q),
        .op_i        (Op[5:0]),
        .zero_i      (zero),
        .sign_i      (sign),
        .halted_i    (halted),
        .irwre_o     (IRWre),
        .pcwre_o     (PCWre),
        .pcsrc_o     (PCSrc),
        .extsel_o    (ExtSel),
        .alusrca_o   (ALUSrcA),
        .alusrcb_o   (ALUSrcB),
        .aluop_o     (ALUOp),
        .regdst_o    (RegDst),
        .regwre_o    (RegWre),
        .dbdatasrc_o (DBDataSrc),
        .nrd_o       (nRD),
        .nwr_o       (nWR)
    );

endmodule
`default_nettype wire
